// File: rtl/VX_gpu_pkg.sv
// Shared AMO encodings, sequencer state type and build-width fallbacks
// for the per-warp AMO read-modify-write sequencer.
`ifndef NUM_THREADS
`define NUM_THREADS 4
`endif
`ifndef NW_BITS
`define NW_BITS 2
`endif
`ifndef NR_BITS
`define NR_BITS 5
`endif

package VX_gpu_pkg;

    localparam int VX_NUM_THREADS = `NUM_THREADS;
    localparam int VX_NW_BITS     = `NW_BITS;
    localparam int VX_NR_BITS     = `NR_BITS;

    localparam logic [3:0] AMO_ADD  = 4'd0;
    localparam logic [3:0] AMO_SWAP = 4'd1;
    localparam logic [3:0] AMO_XOR  = 4'd2;
    localparam logic [3:0] AMO_OR   = 4'd3;
    localparam logic [3:0] AMO_AND  = 4'd4;
    localparam logic [3:0] AMO_MIN  = 4'd5;
    localparam logic [3:0] AMO_MAX  = 4'd6;
    localparam logic [3:0] AMO_MINU = 4'd7;
    localparam logic [3:0] AMO_MAXU = 4'd8;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        COMMIT
    } amo_state_e;

endpackage

// File: rtl/vx_amo_alu_core.sv
// Combinational AMO ALU: combines the old memory word with rs2.
// Unknown opcodes pass the old word through unchanged.
module vx_amo_alu_core
    import VX_gpu_pkg::*;
(
    input  logic [3:0]  op_i,
    input  logic [31:0] old_i,
    input  logic [31:0] rs2_i,
    output logic [31:0] result_o
);

    logic lt_s;
    logic lt_u;

    assign lt_s = $signed(old_i) < $signed(rs2_i);
    assign lt_u = old_i < rs2_i;

    always_comb begin
        // NOTE: default assigned first so every path drives result_o and no latch is inferred.
        result_o = old_i;
        case (op_i)
            AMO_ADD:  result_o = old_i + rs2_i;
            AMO_SWAP: result_o = rs2_i;
            AMO_XOR:  result_o = old_i ^ rs2_i;
            AMO_OR:   result_o = old_i | rs2_i;
            AMO_AND:  result_o = old_i & rs2_i;
            AMO_MIN:  result_o = lt_s ? old_i : rs2_i;
            AMO_MAX:  result_o = lt_s ? rs2_i : old_i;
            AMO_MINU: result_o = lt_u ? old_i : rs2_i;
            AMO_MAXU: result_o = lt_u ? rs2_i : old_i;
            default:  ;
        endcase
    end

endmodule

// File: rtl/vx_amo_sequencer.sv
// Per-warp AMO sequencer: walks active lanes serially doing load/ALU/store,
// then commits old values. VX_AMO_SKIP_SAME_WR_EN drops stores that would not change memory.
module vx_amo_sequencer
    import VX_gpu_pkg::*;
#(
    parameter int CORE_ID   = 0,
    parameter int NUM_LANES = `NUM_THREADS
) (
    input  logic                      clk,
    input  logic                      reset,

    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [3:0]                req_op,
    input  logic [`NW_BITS-1:0]       req_wid,
    input  logic [31:0]               req_PC,
    input  logic [`NR_BITS-1:0]       req_rd,
    input  logic                      req_wb,
    input  logic [NUM_LANES-1:0]      req_tmask,
    input  logic [NUM_LANES*32-1:0]   req_addr,
    input  logic [NUM_LANES*32-1:0]   req_data,

    output logic                      mem_req_valid,
    output logic                      mem_req_rw,
    output logic [31:0]               mem_req_addr,
    output logic [31:0]               mem_req_data,
    input  logic                      mem_req_ready,
    input  logic                      mem_rsp_valid,
    input  logic [31:0]               mem_rsp_data,
    output logic                      mem_rsp_ready,

    output logic                      commit_valid,
    input  logic                      commit_ready,
    output logic [`NW_BITS-1:0]       commit_wid,
    output logic [31:0]               commit_PC,
    output logic [`NR_BITS-1:0]       commit_rd,
    output logic                      commit_wb,
    output logic [NUM_LANES-1:0]      commit_tmask,
    output logic [NUM_LANES*32-1:0]   commit_data
);

    localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    amo_state_e               state_q, state_d;
    logic [NUM_LANES-1:0]     mask_q, mask_d;
    logic [LANE_W-1:0]        lane_q, lane_d;
    logic [LANE_W-1:0]        scan_lane;
    logic [3:0]               op_q;
    logic [`NW_BITS-1:0]      wid_q;
    logic [31:0]              pc_q;
    logic [`NR_BITS-1:0]      rd_q;
    logic                     wb_q;
    logic [NUM_LANES-1:0]     tmask_q;
    logic [31:0]              result_q;
    logic [31:0]              old_q  [NUM_LANES];
    logic [31:0]              addr_q [NUM_LANES];
    logic [31:0]              rs2_q  [NUM_LANES];
    logic [31:0]              alu_result;
    logic                     req_fire;
    logic                     rsp_hit;
    logic                     skip_store;
    logic [31:0]              dbg_core_id_unused;

    assign dbg_core_id_unused = CORE_ID;

    assign req_fire = req_valid && req_ready;
    assign rsp_hit  = (state_q == RD_WAIT) && mem_rsp_valid;

    // Priority encoder: the lowest remaining lane wins.
    always_comb begin
        scan_lane = '0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (mask_q[i]) scan_lane = LANE_W'(i);
        end
    end

    vx_amo_alu_core u_alu (
        .op_i     (op_q),
        .old_i    (mem_rsp_data),
        .rs2_i    (rs2_q[lane_q]),
        .result_o (alu_result)
    );

`ifdef VX_AMO_SKIP_SAME_WR_EN
    assign skip_store = (alu_result == mem_rsp_data);
`else
    assign skip_store = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        lane_d  = lane_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = SCAN;
                    mask_d  = req_tmask;
                end
            end
            SCAN: begin
                if (mask_q == '0) begin
                    state_d = COMMIT;
                end else begin
                    lane_d  = scan_lane;
                    state_d = RD_REQ;
                end
            end
            RD_REQ: begin
                if (mem_req_ready) state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (mem_rsp_valid) begin
                    if (skip_store) begin
                        mask_d[lane_q] = 1'b0;
                        state_d        = SCAN;
                    end else begin
                        state_d = WR_REQ;
                    end
                end
            end
            WR_REQ: begin
                if (mem_req_ready) begin
                    mask_d[lane_q] = 1'b0;
                    state_d        = SCAN;
                end
            end
            COMMIT: begin
                if (commit_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            mask_q   <= '0;
            lane_q   <= '0;
            op_q     <= '0;
            wid_q    <= '0;
            pc_q     <= '0;
            rd_q     <= '0;
            wb_q     <= 1'b0;
            tmask_q  <= '0;
            result_q <= '0;
            for (int i = 0; i < NUM_LANES; i++) old_q[i] <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            lane_q  <= lane_d;
            if (req_fire) begin
                op_q    <= req_op;
                wid_q   <= req_wid;
                pc_q    <= req_PC;
                rd_q    <= req_rd;
                wb_q    <= req_wb;
                tmask_q <= req_tmask;
                for (int i = 0; i < NUM_LANES; i++) old_q[i] <= '0;
            end
            if (rsp_hit) begin
                old_q[lane_q] <= mem_rsp_data;
                result_q      <= alu_result;
            end
        end
    end

    // NOTE: operand payload is only read after a request latches it, so it needs no reset.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                addr_q[i] <= req_addr[i*32 +: 32];
                rs2_q[i]  <= req_data[i*32 +: 32];
            end
        end
    end

    assign req_ready     = (state_q == IDLE) && !reset;
    assign mem_req_valid = (state_q == RD_REQ) || (state_q == WR_REQ);
    assign mem_req_rw    = (state_q == WR_REQ);
    assign mem_req_addr  = mem_req_valid ? addr_q[lane_q] : '0;
    assign mem_req_data  = (state_q == WR_REQ) ? result_q : '0;
    assign mem_rsp_ready = 1'b1;

    assign commit_valid = (state_q == COMMIT);
    assign commit_wid   = wid_q;
    assign commit_PC    = pc_q;
    assign commit_rd    = rd_q;
    assign commit_wb    = wb_q;
    assign commit_tmask = tmask_q;

    always_comb begin
        commit_data = '0;
        for (int i = 0; i < NUM_LANES; i++) commit_data[i*32 +: 32] = old_q[i];
    end

endmodule

// File: doc/vx_amo_sequencer.md
# vx_amo_sequencer

Per-warp atomic memory operation (AMO) read-modify-write sequencer for the LSU path.
- Accepts one AMO instruction at a time and walks its active lanes serially.
- Per active lane: issues a load, combines the returned word with the lane's rs2 value through an internal AMO ALU, then issues the store.
- Commits the old memory values to the writeback stage, per RISC-V AMO semantics.

## Interface
- CORE_ID, 0, core index; used only for debug trace.
- NUM_LANES, `NUM_THREADS, lanes per request.
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  AMO request valid.
- req_ready  out  1  high only in IDLE.
- req_op  in  4  AMO op: ADD=0, SWAP=1, XOR=2, OR=3, AND=4, MIN=5, MAX=6, MINU=7, MAXU=8.
- req_wid  in  `NW_BITS  warp id.
- req_PC  in  32  instruction PC.
- req_rd  in  `NR_BITS  destination register.
- req_wb  in  1  writeback enable.
- req_tmask  in  NUM_LANES  active lanes.
- req_addr  in  NUM_LANES×32  per-lane word address (rs1).
- req_data  in  NUM_LANES×32  per-lane operand (rs2).
- mem_req_valid  out  1  memory request valid.
- mem_req_rw  out  1  1=store, 0=load.
- mem_req_addr  out  32  request address.
- mem_req_data  out  32  store data.
- mem_req_ready  in  1  memory accepts request.
- mem_rsp_valid  in  1  load response valid.
- mem_rsp_data  in  32  loaded word.
- mem_rsp_ready  out  1  constant 1.
- commit_valid  out  1  commit valid.
- commit_ready  in  1  commit accepted.
- commit_wid, commit_PC, commit_rd, commit_wb, commit_tmask  out  as request fields  latched request fields.
- commit_data  out  NUM_LANES×32  old memory value per lane; inactive lanes 0.

## Operation
- FSM states:
  - IDLE: on req fire, latch all fields; remaining mask = tmask; go to SCAN.
  - SCAN: lowest set bit of remaining mask selects the lane, then go to RD_REQ; if mask is empty, go to COMMIT.
  - RD_REQ: drive load for lane; on fire, go to RD_WAIT.
  - RD_WAIT: on mem_rsp_valid, store old=rsp_data into commit_data[lane] and new=alu(op, old, rs2[lane]) into the result register; go to WR_REQ.
  - WR_REQ: drive store of the result; on fire, clear lane bit and go to SCAN.
  - COMMIT: hold commit_valid until commit_ready; then go to IDLE.
- ALU:
  - result = f(old, rs2).
  - MIN/MAX compare signed 32-bit; MINU/MAXU compare unsigned.
  - SWAP yields rs2.
  - Ops 9–15 yield old unchanged; the store is still issued.
- At most one memory request is outstanding. The memory returns responses in order and treats stores as fire-and-forget.
- mem_rsp_valid outside RD_WAIT is consumed and dropped.
- mem_req_valid stays asserted, with address, data and rw stable, until ready.
- A new request is never accepted until the commit handshake completes; IDLE→IDLE overlap is disallowed.

## Timing
- Reset (async, any state): state=IDLE; all outputs 0 except mem_rsp_ready=1. req_ready=1 after reset deasserts. An in-flight lane is abandoned.
- Lane cost with zero memory stall and a response N cycles after load fire: 1 (SCAN) + 1 (RD_REQ) + N (RD_WAIT) + 1 (WR_REQ).
- Request with tmask=0: fire cycle → SCAN → COMMIT; commit_valid is asserted 2 cycles after req fire.
- Total latency = 1 + Σ lane cost + 1 cycle to commit_valid.
- commit_valid, PC and other commit fields are registered and stable while waiting.

## Configuration
- VX_AMO_SKIP_SAME_WR_EN defined:
  - In RD_WAIT, if new == old, skip WR_REQ: clear the lane bit and go directly to SCAN, with no store issued.
- Undefined:
  - A store is always issued, including for AND/OR results equal to old and for illegal ops.

## Structure
- VX_gpu_pkg holds:
  - the AMO op encoding localparams (AMO_ADD…AMO_MAXU);
  - the state enum (IDLE, SCAN, RD_REQ, RD_WAIT, WR_REQ, COMMIT).
- Sub-module vx_amo_alu_core: purely combinational (op, old, rs2) → result; instantiated once.
- Lane selection uses a priority encoder over the remaining mask.

## Test plan
- ADD, tmask=0001, mem[0x100]=5, rs2=3:
  - load 0x100;
  - store 8 to 0x100;
  - commit_data[0]=5;
  - exactly one load and one store.
- MIN vs MINU, old=0xFFFFFFFF, rs2=1:
  - MIN stores 0xFFFFFFFF;
  - MINU stores 1.
- tmask=1010, NUM_LANES=4:
  - lanes processed in order 1 then 3;
  - lanes 0 and 2 produce no memory traffic;
  - commit_data[0]=commit_data[2]=0.
- tmask=0000: no memory traffic; commit_valid 2 cycles after req fire.
- Backpressure:
  - mem_req_ready low 3 cycles during RD_REQ and WR_REQ: request stays stable;
  - commit_ready low 5 cycles: req_ready stays 0.
- Reset asserted in RD_WAIT:
  - outputs clear immediately;
  - a late response is dropped;
  - a next request SWAP rs2=7 stores 7 correctly.
- With VX_AMO_SKIP_SAME_WR_EN: OR with old=0xF, rs2=0x1 gives no store and commit_data=0xF.
